// File: rtl/result_frame_writer.sv
// Writer side of the result frame memory: buffers a row-major pixel stream through
// a 2-entry FIFO and writes it linearly into the frame memory when the port is granted.
module result_frame_writer #(
  parameter int H_PIXELS = 480,
  parameter int V_LINES  = 320,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 18
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pix_valid,
  input  logic [DATA_W-1:0] i_pix_data,
  output logic              o_pix_ready,
  input  logic              i_mem_gnt,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [9:0]        o_h_pos,
  output logic [9:0]        o_v_pos
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_RUN   | accepting pixels and draining the FIFO
  // S_FLUSH | all pixels accepted, draining the FIFO
  // S_DONE  | final write on the bus, frame_done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam int TOTAL = H_PIXELS * V_LINES;
  localparam logic [ADDR_W:0]   TOTAL_C   = (ADDR_W+1)'(TOTAL);
  localparam logic [ADDR_W:0]   LAST_ACC  = (ADDR_W+1)'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [9:0]        H_LAST    = 10'(H_PIXELS - 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic [ADDR_W:0]   r_acc_cnt;
  logic [ADDR_W-1:0] r_waddr;
  logic [9:0]        r_wcol;
  logic [9:0]        r_wrow;

  logic w_push;
  logic w_pop;

  // Ready depends only on registered state so it never loops back through valid.
  assign o_pix_ready  = (r_state == S_RUN) && (r_count < 2'd2) && (r_acc_cnt < TOTAL_C);
  assign w_push       = i_pix_valid && o_pix_ready;
  assign w_pop        = ((r_state == S_RUN) || (r_state == S_FLUSH)) && (r_count != 2'd0) && i_mem_gnt;
  assign o_busy       = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign o_frame_done = (r_state == S_DONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_acc_cnt   <= '0;
      r_waddr     <= '0;
      r_wcol      <= '0;
      r_wrow      <= '0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_h_pos     <= '0;
      o_v_pos     <= '0;
    end else begin
      o_mem_we <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_RUN;
            r_acc_cnt <= '0;
            r_waddr   <= '0;
            r_wcol    <= '0;
            r_wrow    <= '0;
            o_h_pos   <= '0;
            o_v_pos   <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
          end
        end
        S_RUN: begin
          if (w_push && (r_acc_cnt == LAST_ACC)) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (w_pop && (r_waddr == LAST_ADDR)) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_push) begin
        r_fifo[r_wr_ptr] <= i_pix_data;
        r_wr_ptr         <= ~r_wr_ptr;
        r_acc_cnt        <= r_acc_cnt + (ADDR_W+1)'(1);
      end

      if (w_pop) begin
        r_rd_ptr    <= ~r_rd_ptr;
        o_mem_we    <= 1'b1;
        o_mem_addr  <= r_waddr;
        o_mem_wdata <= r_fifo[r_rd_ptr];
        o_h_pos     <= r_wcol;
        o_v_pos     <= r_wrow;
        r_waddr     <= r_waddr + ADDR_W'(1);
        if (r_wcol == H_LAST) begin
          r_wcol <= '0;
          r_wrow <= r_wrow + 10'd1;
        end else begin
          r_wcol <= r_wcol + 10'd1;
        end
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_frame_writer.sv
// Scoreboard bench for result_frame_writer on a 4x3 frame: the driver queues expected
// writes as pixels are accepted, a negedge monitor pops and compares every mem_we.
module tb_result_frame_writer;
  localparam int H   = 4;
  localparam int V   = 3;
  localparam int AW  = 18;
  localparam int DW  = 8;
  localparam int TOT = H * V;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic          mem_gnt;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy;
  logic          frame_done;
  logic [9:0]    h_pos;
  logic [9:0]    v_pos;

  result_frame_writer #(.H_PIXELS(H), .V_LINES(V), .DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pix_valid(pix_valid),
    .i_pix_data(pix_data), .o_pix_ready(pix_ready), .i_mem_gnt(mem_gnt),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_busy(busy), .o_frame_done(frame_done), .o_h_pos(h_pos), .o_v_pos(v_pos)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  int            checks = 0;
  int            errors = 0;
  int            wr_cnt = 0;
  int            fd_cnt = 0;
  int            acc_cnt = 0;
  int            exp_addr = 0;
  int            first_acc = 0;
  int            first_we = 0;
  int            last_we = 0;
  bit            gnt_rand = 1'b0;
  logic [DW-1:0] mem_model [TOT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (mem_we) begin
        wr_cnt++;
        if (wr_cnt == 1) first_we = cyc;
        last_we = cyc;
        if (mem_addr < AW'(TOT)) mem_model[int'(mem_addr)] = mem_wdata;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %0h, required no write", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e.a));
          chk("wr_data", 32'(mem_wdata), 32'(e.d));
          chk("frame_done_on_write", 32'(frame_done), 32'(e.a == AW'(TOT - 1)));
          chk("h_pos", 32'(h_pos), 32'(e.a) % H);
          chk("v_pos", 32'(v_pos), 32'(e.a) / H);
        end
      end
      if (frame_done) begin
        fd_cnt++;
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("done_with_we", 32'(mem_we), 32'd1);
      end
    end
  end

  // Random grant generator
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (gnt_rand) mem_gnt = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [DW-1:0] d);
    int t = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    forever begin
      @(negedge clk);
      if (pix_ready) break;
      t++;
      if (t > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: pixel %0h not accepted, required acceptance", d);
        break;
      end
    end
    if (pix_ready) begin
      if (acc_cnt == 0) first_acc = cyc;
      exp_q.push_back('{a: AW'(exp_addr), d: d});
      exp_addr++;
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic new_frame();
    exp_addr = 0;
    acc_cnt  = 0;
    wr_cnt   = 0;
    fd_cnt   = 0;
    @(posedge clk);
    #1;
    chk("busy_before_start", 32'(busy), 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_frame();
    int t = 0;
    while (wr_cnt < TOT && t < 300) begin
      @(posedge clk);
      #2;
      t++;
    end
    repeat (3) @(posedge clk);
    #2;
    chk("frame_write_count", 32'(wr_cnt), 32'(TOT));
    chk("frame_done_count", 32'(fd_cnt), 32'd1);
    chk("busy_after_frame", 32'(busy), 32'd0);
    chk("final_h_pos", 32'(h_pos), 32'(H - 1));
    chk("final_v_pos", 32'(v_pos), 32'(V - 1));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_h_pos"}, 32'(h_pos), 32'd0);
    chk({tag, "_v_pos"}, 32'(v_pos), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int w0;
    int t;
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0; mem_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_vals("reset");

    // Frame 1: continuous stream, grant held, then valid held past the last pixel
    new_frame();
    for (int k = 0; k < TOT; k++) send(DW'(k));
    pix_valid = 1'b1;
    pix_data  = 8'hEE;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("ready_after_total", 32'(pix_ready), 32'd0);
    end
    pix_valid = 1'b0;
    wait_frame();
    chk("first_write_latency", 32'(first_we - first_acc), 32'd2);
    chk("frame_time", 32'(last_we - first_acc), 32'(TOT + 1));

    // Frame 2: grant withheld for 5 cycles mid-frame
    new_frame();
    fork
      begin
        for (int k = 0; k < TOT; k++) send(8'h30 + DW'(k));
      end
      begin
        t = 0;
        while (acc_cnt < 4 && t < 100) begin
          @(posedge clk);
          #2;
          t++;
        end
        mem_gnt = 1'b0;
        a0 = acc_cnt;
        @(posedge clk);
        #2;
        w0 = wr_cnt;
        repeat (4) @(posedge clk);
        #2;
        chk("stall_no_write", 32'(wr_cnt), 32'(w0));
        chk("stall_ready_low", 32'(pix_ready), 32'd0);
        chk("stall_accepts_le2", 32'(acc_cnt - a0 <= 2), 32'd1);
        mem_gnt = 1'b1;
      end
    join
    wait_frame();

    // Frame 3: random valid gaps and random grant, start pulsed mid-frame
    for (int i = 0; i < TOT; i++) mem_model[i] = 8'hFF;
    gnt_rand = 1'b1;
    new_frame();
    for (int k = 0; k < TOT; k++) begin
      if (k == 6) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      send(8'h60 + DW'(k));
      gap($urandom_range(0, 3));
    end
    @(posedge clk);
    #3;
    gnt_rand = 1'b0;
    mem_gnt  = 1'b1;
    wait_frame();
    for (int i = 0; i < TOT; i++) chk("mem_model", 32'(mem_model[i]), 32'(8'h60 + DW'(i)));

    // Frame 4: reset after a few writes
    new_frame();
    for (int k = 0; k < 7; k++) send(8'h90 + DW'(k));
    t = 0;
    while (wr_cnt < 5 && t < 100) begin
      @(posedge clk);
      #2;
      t++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("midframe_reset");
    rst = 1'b0;
    exp_q.delete();
    gap(6);

    // Frame 5: clean frame after reset starts again at address 0
    new_frame();
    for (int k = 0; k < TOT; k++) send(8'hC0 + DW'(k));
    wait_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
